// File: rtl/ctr_share_pkg.sv
// Shared types and helpers for the shared-counter arbiter: FSM state encoding
// and the round-robin first-set search.
package ctr_share_pkg;

   localparam int unsigned MAX_REQ = 32;
   localparam int unsigned IDX_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // First set bit of req searching upward from ptr, wrapping at num_req.
   // Only the first num_req bits of req are considered.
   function automatic logic [IDX_W-1:0] rr_first(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input logic [IDX_W:0]     num_req);
      logic [IDX_W:0]   idx;
      logic [IDX_W-1:0] pick;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = {1'b0, ptr} + (IDX_W+1)'(i);
         // ptr < num_req and i < num_req, so one subtraction is enough to wrap
         if (idx >= num_req) idx = idx - num_req;
         if (!found && ((IDX_W+1)'(i) < num_req) && req[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[IDX_W-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ctr_share_arb_if.sv
// Requester-side bundle of the shared-counter arbiter: requests, load values,
// grant/done strobes and the visible counter value.
interface ctr_share_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 4
);

   logic [NUM_REQ-1:0]       req_i;
   logic [NUM_REQ*CNT_W-1:0] req_val_i;
   logic [NUM_REQ-1:0]       gnt_o;
   logic [NUM_REQ-1:0]       done_o;
   logic                     busy_o;
   logic [CNT_W-1:0]         count_o;

   modport master (
      output req_i,
      output req_val_i,
      input  gnt_o,
      input  done_o,
      input  busy_o,
      input  count_o
   );

   modport slave (
      input  req_i,
      input  req_val_i,
      output gnt_o,
      output done_o,
      output busy_o,
      output count_o
   );

endinterface

// File: rtl/ld_ctr.sv
// Loadable up-counter with terminal-count flag; load wins over enable.
module ld_ctr #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_o <= '0;
      end else if (load_i) begin
         count_o <= load_val_i;
      end else if (en_i) begin
         count_o <= count_o + CNT_W'(1);
      end
   end

   assign tc_o = &count_o;

endmodule

// File: rtl/ctr_share_arb.sv
// Round-robin owner of one shared loadable counter: load the winner's value,
// count to all-ones, pulse done to the owner, then release.
module ctr_share_arb
   import ctr_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   ctr_share_arb_if.slave   bus
);

   localparam int unsigned OWN_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   val_q,   val_d;
   logic [OWN_W-1:0]   ptr_q,   ptr_d;

   logic [OWN_W-1:0]   pick;
   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] gnt, done;
   logic               busy;
   logic               ctr_load, ctr_en, ctr_tc;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   req_val [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_val
      assign req_val[g] = bus.req_val_i[g*CNT_W +: CNT_W];
   end

   assign pick     = OWN_W'(rr_first(MAX_REQ'(bus.req_i), IDX_W'(ptr_q),
                                     (IDX_W+1)'(NUM_REQ)));
   assign owner_oh = NUM_REQ'(1'b1) << owner_q;

   // State, owner, captured value and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         val_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         val_q   <= val_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state, counter control and output decode
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      val_d    = val_q;
      ptr_d    = ptr_q;
      ctr_load = 1'b0;
      ctr_en   = 1'b0;
      gnt      = '0;
      done     = '0;
      busy     = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (|bus.req_i) begin
               owner_d = pick;
               val_d   = req_val[pick];
               state_d = LOAD;
            end
         end
         LOAD: begin
            ctr_load = 1'b1;
            gnt      = owner_oh;
            state_d  = RUN;
         end
         RUN: begin
            gnt = owner_oh;
            // Stop on all-ones so the counter never wraps
            if (ctr_tc) begin
               state_d = DONE;
            end else begin
               ctr_en = 1'b1;
            end
         end
         DONE: begin
            done    = owner_oh;
            ptr_d   = (owner_q == OWN_W'(NUM_REQ-1)) ? '0 : owner_q + OWN_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   ld_ctr #(
      .CNT_W (CNT_W)
   ) u_ld_ctr (
      .clk        (clk),
      .reset      (reset),
      .en_i       (ctr_en),
      .load_i     (ctr_load),
      .load_val_i (val_q),
      .count_o    (count),
      .tc_o       (ctr_tc)
   );

   assign bus.gnt_o   = gnt;
   assign bus.done_o  = done;
   assign bus.busy_o  = busy;
   assign bus.count_o = count;

endmodule

// File: tb/tb_ctr_share_arb.sv
// Bench for ctr_share_arb: a timestamp-based job model predicts every cycle's
// grant, done, busy and count values from the arbitration and latency rules.
module tb_ctr_share_arb;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 4;
   localparam int unsigned NW  = N * W;
   localparam int          TOP = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   ctr_share_arb_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

   ctr_share_arb #(.NUM_REQ(N), .CNT_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: at most one job, described by its sample cycle, owner and value
   bit           m_active;
   int           m_t, m_d, m_owner, m_val, m_ptr, m_prev;
   logic [N-1:0] e_gnt, e_done;
   logic         e_busy;
   logic [W-1:0] e_cnt;

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int i = 0; i < int'(N); i++)
         if (req[(ptr + i) % N]) return (ptr + i) % N;
      return 0;
   endfunction

   function automatic logic [NW-1:0] all_vals(input logic [W-1:0] v);
      return {N{v}};
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_ptr    = 0;
      m_prev   = 0;
   endtask

   // Expected outputs for the current cycle
   task automatic model_expect();
      if (m_active && cyc > m_d) begin
         m_active = 1'b0;
         m_prev   = TOP;
      end
      e_gnt  = '0;
      e_done = '0;
      e_busy = 1'b0;
      e_cnt  = W'(m_prev);
      if (m_active) begin
         e_busy = 1'b1;
         if (cyc <= m_d - 1) e_gnt = N'(1) << m_owner;
         if (cyc == m_d)     e_done = N'(1) << m_owner;
         if (cyc >= m_t + 2) e_cnt = (cyc >= m_d) ? W'(TOP) : W'(m_val + (cyc - m_t - 2));
      end
   endtask

   task automatic model_decide(input logic [N-1:0] req, input logic [NW-1:0] vals);
      if (!m_active && req != '0) begin
         m_owner  = rr_pick(req, m_ptr);
         m_val    = int'(vals[m_owner*W +: W]);
         m_t      = cyc;
         m_d      = m_t + 3 + (TOP - m_val);
         m_ptr    = (m_owner + 1) % N;
         m_active = 1'b1;
      end
   endtask

   // One clock: compute expectations, then drive the inputs for this cycle
   task automatic tick(input logic [N-1:0] req, input logic [NW-1:0] vals, input logic rst);
      @(posedge clk);
      #1;
      cyc++;
      model_expect();
      reset         = rst;
      bus.req_i     = req;
      bus.req_val_i = vals;
      if (rst) model_reset();
      else     model_decide(req, vals);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req_i = '0;
      model_reset();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_active; k++) tick('0, NW'($urandom), 1'b0);
   endtask

   task automatic test_reset();
      bus.req_i     = '0;
      bus.req_val_i = '0;
      reset         = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 4;
      if (bus.gnt_o   !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt_o); end
      if (bus.done_o  !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", bus.done_o); end
      if (bus.busy_o  !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      if (bus.count_o !== 4'h0)    begin errors++; $display("FAIL reset_count got %h want 0", bus.count_o); end
      tick('0, '0, 1'b0);
   endtask

   task automatic test_single();
      int t0;
      bit seen = 1'b0;
      do_reset();
      tick(4'b0001, all_vals(4'hC), 1'b0);
      t0 = cyc;
      for (int k = 1; k <= 8; k++) begin
         tick(seen ? 4'b0000 : 4'b0001, all_vals(4'hC), 1'b0);
         checks += 4;
         if (bus.gnt_o   !== e_gnt)  begin errors++; $display("FAIL single_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o  !== e_done) begin errors++; $display("FAIL single_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (bus.busy_o  !== e_busy) begin errors++; $display("FAIL single_busy cyc %0d got %b want %b", cyc, bus.busy_o, e_busy); end
         if (bus.count_o !== e_cnt)  begin errors++; $display("FAIL single_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
         if (cyc == t0 + 2) begin
            checks++;
            if (bus.count_o !== 4'hC) begin errors++; $display("FAIL single_first_count got %h want c", bus.count_o); end
         end
         if (cyc == t0 + 6) begin
            checks++;
            if (bus.done_o !== 4'b0001) begin errors++; $display("FAIL single_done_t6 got %b want 0001", bus.done_o); end
         end
         if (cyc == t0 + 7) begin
            checks++;
            if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_idle_t7 got %b want 0", bus.busy_o); end
         end
         if (bus.gnt_o[0]) seen = 1'b1;
      end
   endtask

   task automatic test_pair();
      logic [N-1:0] pend = 4'b1010;
      logic [N-1:0] prevg = '0;
      logic [N-1:0] ord [4];
      int ng = 0;
      int dn [N];
      for (int i = 0; i < int'(N); i++) dn[i] = 0;
      for (int i = 0; i < 4; i++) ord[i] = '0;
      do_reset();
      for (int k = 0; k < 14; k++) begin
         tick(pend, all_vals(4'hE), 1'b0);
         checks += 3;
         if (bus.gnt_o   !== e_gnt)  begin errors++; $display("FAIL pair_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o  !== e_done) begin errors++; $display("FAIL pair_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (bus.count_o !== e_cnt)  begin errors++; $display("FAIL pair_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
         if (bus.gnt_o != '0 && prevg == '0) begin
            if (ng < 4) ord[ng] = bus.gnt_o;
            ng++;
         end
         prevg = bus.gnt_o;
         pend  = pend & ~bus.gnt_o;
         for (int i = 0; i < int'(N); i++) dn[i] += int'(bus.done_o[i]);
      end
      checks += 5;
      if (ng != 2)              begin errors++; $display("FAIL pair_grant_count got %0d want 2", ng); end
      if (ord[0] !== 4'b0010)   begin errors++; $display("FAIL pair_first got %b want 0010", ord[0]); end
      if (ord[1] !== 4'b1000)   begin errors++; $display("FAIL pair_second got %b want 1000", ord[1]); end
      if (dn[1] != 1)           begin errors++; $display("FAIL pair_done1 got %0d want 1", dn[1]); end
      if (dn[3] != 1)           begin errors++; $display("FAIL pair_done3 got %0d want 1", dn[3]); end
   endtask

   task automatic test_fairness();
      logic [N-1:0] prevg = '0;
      logic [N-1:0] ord [5];
      logic [N-1:0] want [5];
      int gc [5];
      int ng = 0;
      want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin ord[i] = '0; gc[i] = 0; end
      do_reset();
      for (int k = 0; k < 22; k++) begin
         tick(4'b1111, all_vals(4'hF), 1'b0);
         checks += 2;
         if (bus.gnt_o  !== e_gnt)  begin errors++; $display("FAIL fair_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o !== e_done) begin errors++; $display("FAIL fair_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (bus.gnt_o != '0 && prevg == '0) begin
            if (ng < 5) begin ord[ng] = bus.gnt_o; gc[ng] = cyc; end
            ng++;
         end
         prevg = bus.gnt_o;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ord[i] !== want[i]) begin errors++; $display("FAIL fair_order idx %0d got %b want %b", i, ord[i], want[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (gc[i+1] - gc[i] != 4) begin errors++; $display("FAIL fair_spacing idx %0d got %0d want 4", i, gc[i+1] - gc[i]); end
      end
   endtask

   task automatic test_val_max();
      int t0;
      drain();
      tick(4'b0100, all_vals(4'hF), 1'b0);
      t0 = cyc;
      for (int k = 1; k <= 5; k++) begin
         tick('0, all_vals(4'hF), 1'b0);
         checks += 3;
         if (bus.gnt_o   !== e_gnt)  begin errors++; $display("FAIL max_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o  !== e_done) begin errors++; $display("FAIL max_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (bus.count_o !== e_cnt)  begin errors++; $display("FAIL max_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
         if (cyc == t0 + 2) begin
            checks++;
            if (bus.gnt_o !== 4'b0100 || bus.count_o !== 4'hF) begin
               errors++; $display("FAIL max_run gnt %b count %h want 0100 f", bus.gnt_o, bus.count_o);
            end
         end
         if (cyc == t0 + 3) begin
            checks++;
            if (bus.done_o !== 4'b0100) begin errors++; $display("FAIL max_done_t3 got %b want 0100", bus.done_o); end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int t0, t1;
      logic [N-1:0] pend = 4'b1010;
      do_reset();
      tick(4'b0100, all_vals(4'hB), 1'b0);
      t0 = cyc;
      for (int k = 1; k <= 4; k++) begin
         tick(k == 1 ? 4'b0100 : 4'b0000, all_vals(4'hB), 1'b0);
         checks++;
         if (bus.count_o !== e_cnt) begin errors++; $display("FAIL mid_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
      end
      checks++;
      if (bus.count_o !== 4'hD) begin errors++; $display("FAIL mid_pre_reset got %h want d", bus.count_o); end
      reset = 1'b1;
      #1;
      model_reset();
      checks += 4;
      if (bus.gnt_o   !== 4'b0000) begin errors++; $display("FAIL mid_gnt got %b want 0000", bus.gnt_o); end
      if (bus.count_o !== 4'h0)    begin errors++; $display("FAIL mid_cnt got %h want 0", bus.count_o); end
      if (bus.busy_o  !== 1'b0)    begin errors++; $display("FAIL mid_busy got %b want 0", bus.busy_o); end
      if (bus.done_o  !== 4'b0000) begin errors++; $display("FAIL mid_done got %b want 0000", bus.done_o); end
      tick('0, '0, 1'b1);
      tick(pend, all_vals(4'h7), 1'b0);
      t1 = cyc;
      for (int k = 1; k <= 24; k++) begin
         tick(pend, all_vals(4'h7), 1'b0);
         checks += 2;
         if (bus.gnt_o  !== e_gnt)  begin errors++; $display("FAIL mid_after_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o !== e_done) begin errors++; $display("FAIL mid_after_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (cyc == t1 + 1) begin
            checks++;
            if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL mid_next_owner got %b want 0010", bus.gnt_o); end
         end
         pend = pend & ~bus.gnt_o;
      end
   endtask

   task automatic test_hold_change();
      int t0;
      logic [NW-1:0] v;
      drain();
      v = NW'($urandom);
      v[3*W +: W] = 4'h3;
      tick(4'b1000, v, 1'b0);
      t0 = cyc;
      for (int k = 1; k <= 18; k++) begin
         tick('0, NW'($urandom), 1'b0);
         checks += 2;
         if (bus.count_o !== e_cnt)  begin errors++; $display("FAIL hold_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
         if (bus.done_o  !== e_done) begin errors++; $display("FAIL hold_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (cyc == t0 + 15) begin
            checks++;
            if (bus.done_o !== 4'b1000) begin errors++; $display("FAIL hold_done_t15 got %b want 1000", bus.done_o); end
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] pend = '0;
      for (int k = 0; k < 400; k++) begin
         pend = pend | (N'($urandom) & N'($urandom));
         if ($urandom_range(0, 15) == 0) pend = pend & N'($urandom);
         tick(pend, NW'($urandom), 1'b0);
         checks += 5;
         if (bus.gnt_o   !== e_gnt)  begin errors++; $display("FAIL rand_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, e_gnt); end
         if (bus.done_o  !== e_done) begin errors++; $display("FAIL rand_done cyc %0d got %b want %b", cyc, bus.done_o, e_done); end
         if (bus.busy_o  !== e_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", cyc, bus.busy_o, e_busy); end
         if (bus.count_o !== e_cnt)  begin errors++; $display("FAIL rand_count cyc %0d got %h want %h", cyc, bus.count_o, e_cnt); end
         if (!$onehot0(bus.gnt_o) || !$onehot0(bus.done_o) || (|bus.gnt_o && |bus.done_o)) begin
            errors++; $display("FAIL rand_onehot cyc %0d gnt %b done %b", cyc, bus.gnt_o, bus.done_o);
         end
         pend = pend & ~bus.gnt_o;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_pair();
      test_fairness();
      test_val_max();
      test_reset_mid_run();
      test_hold_change();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
